// File: rtl/knn_nat_driver.sv
// rtl/knn_nat_driver.sv - native-bus initiator that runs KNN queries per streamed point
// Writes x/y, polls done, selects and reads back HW_K results, streams them out.
module knn_nat_driver #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int HW_K     = 4,
  parameter int A_DATA_1 = 0,
  parameter int A_DATA_2 = 1,
  parameter int A_SEL    = 2,
  parameter int A_DONE   = 3,
  parameter int A_OUT    = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               n_points,
  input  logic                      pt_valid,
  output logic                      pt_ready,
  input  logic [DATA_W-1:0]         pt_x,
  input  logic [DATA_W-1:0]         pt_y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(HW_K)-1:0]   res_idx,
  output logic                      res_last,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      m_valid,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_ready
);

  localparam int K_W = $clog2(HW_K);
  localparam int P_W = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, WR_X, WR_Y, POLL, WR_SEL, RD_OUT, EMIT, FIN
  } state_t;

  state_t              state_q, state_d;
  logic                gap_q, gap_d;
  logic [15:0]         remain_q, remain_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [P_W-1:0]      poll_q, poll_d;
  logic [DATA_W-1:0]   x_q, x_d, y_q, y_d, res_q, res_d;
  logic                flag_q, flag_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;

  logic                bus_state, xfer, bus_wr;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;

  // Every bus state owns one request phase followed by one idle gap cycle.
  assign bus_state = (state_q == WR_X) || (state_q == WR_Y) || (state_q == POLL) ||
                     (state_q == WR_SEL) || (state_q == RD_OUT);
  assign m_valid   = bus_state && !gap_q;
  assign xfer      = m_valid && m_ready;

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wr    = 1'b0;
    case (state_q)
      WR_X:   begin bus_addr = ADDR_W'(A_DATA_1); bus_wdata = x_q; bus_wr = 1'b1; end
      WR_Y:   begin bus_addr = ADDR_W'(A_DATA_2); bus_wdata = y_q; bus_wr = 1'b1; end
      POLL:   bus_addr = ADDR_W'(A_DONE);
      WR_SEL: begin bus_addr = ADDR_W'(A_SEL); bus_wdata = DATA_W'(k_q); bus_wr = 1'b1; end
      RD_OUT: bus_addr = ADDR_W'(A_OUT);
      default: ;
    endcase
  end

  assign m_addr      = m_valid ? bus_addr : '0;
  assign m_wdata     = m_valid ? bus_wdata : '0;
  assign m_wstrb     = {(DATA_W/8){m_valid && bus_wr}};
  assign pt_ready    = (state_q == FETCH);
  assign res_valid   = (state_q == EMIT);
  assign res_idx     = (state_q == EMIT) ? k_q : '0;
  assign res_data    = res_q;
  assign res_last    = (state_q == EMIT) && (k_q == K_W'(HW_K - 1)) && (remain_q == 16'd1);
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    remain_d = remain_q;
    k_d      = k_q;
    poll_d   = poll_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    flag_d   = flag_q;
    terr_d   = terr_q;
    done_d   = 1'b0;
    if (bus_state) begin
      if (gap_q)     gap_d = 1'b0;
      else if (xfer) gap_d = 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        terr_d   = 1'b0;
        remain_d = n_points;
        state_d  = (n_points == 16'd0) ? FIN : FETCH;
      end
      FETCH: if (pt_valid) begin
        x_d     = pt_x;
        y_d     = pt_y;
        state_d = WR_X;
      end
      WR_X: if (gap_q) state_d = WR_Y;
      WR_Y: if (gap_q) begin
        poll_d  = '0;
        state_d = POLL;
      end
      POLL: begin
        if (xfer) begin
          flag_d = m_rdata[0];
          if (!m_rdata[0]) poll_d = poll_q + 1'b1;
        end else if (gap_q) begin
          if (flag_q) begin
            k_d     = '0;
            state_d = WR_SEL;
          end else if (poll_q == P_W'(POLL_MAX)) begin
            terr_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      WR_SEL: if (gap_q) state_d = RD_OUT;
      RD_OUT: begin
        if (xfer)  res_d   = m_rdata;
        if (gap_q) state_d = EMIT;
      end
      EMIT: if (res_ready) begin
        if (k_q != K_W'(HW_K - 1)) begin
          k_d     = k_q + 1'b1;
          state_d = WR_SEL;
        end else if (remain_q > 16'd1) begin
          remain_d = remain_q - 16'd1;
          state_d  = FETCH;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gap_q    <= 1'b0;
      remain_q <= '0;
      k_q      <= '0;
      poll_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      remain_q <= remain_d;
      k_q      <= k_d;
      poll_q   <= poll_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
    end
  end

endmodule

// File: tb/tb_knn_nat_driver.sv
// tb/tb_knn_nat_driver.sv - directed self-checking bench for knn_nat_driver
// Behavioural KNN responder with stall/done controls, bus and result loggers.
module tb_knn_nat_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_points = '0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [31:0] pt_x = '0;
  logic [31:0] pt_y = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [1:0]  res_idx;
  logic        res_last;
  logic        busy, done, timeout_err;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready = 1'b0;

  knn_nat_driver #(.POLL_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last), .busy(busy), .done(done),
    .timeout_err(timeout_err), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          stall_x = 0;
  int          done_after = 0;
  int          poll_reads = 0;
  int          wait_q = 0;
  logic [31:0] sel_reg = '0;
  logic [4:0]  log_addr [256];
  logic [31:0] log_wdata [256];
  logic        log_wr [256];
  int          log_n = 0;
  logic [31:0] r_data [64];
  logic [1:0]  r_idx [64];
  logic        r_last [64];
  int          res_n = 0;
  int          rv_cnt = 0;
  int          done_n = 0;
  logic        p_valid = 1'b0, p_done = 1'b0;
  logic [4:0]  p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;
  int          stab_viol = 0, gap_viol = 0, vlen = 0, x_len = 0;

  always_comb begin
    m_rdata = '0;
    if (m_addr == 5'd3)
      m_rdata = {31'b0, (done_after >= 0) && (poll_reads >= done_after)};
    else if (m_addr == 5'd4)
      m_rdata = 32'h100 + sel_reg;
  end

  // Responder: ready is registered from valid, so every transfer is at least two cycles.
  always @(posedge clk) begin
    if (!rst) begin
      m_ready <= 1'b0;
      wait_q  <= 0;
    end else if (m_valid && m_ready) begin
      m_ready <= 1'b0;
      wait_q  <= 0;
      log_addr[log_n]  <= m_addr;
      log_wdata[log_n] <= m_wdata;
      log_wr[log_n]    <= (m_wstrb != 4'd0);
      log_n            <= log_n + 1;
      if (m_wstrb == 4'hf && m_addr == 5'd2) sel_reg <= m_wdata;
      if (m_wstrb == 4'hf && m_addr == 5'd1) poll_reads <= 0;
      if (m_wstrb == 4'h0 && m_addr == 5'd3) poll_reads <= poll_reads + 1;
    end else if (m_valid) begin
      if (wait_q >= ((m_addr == 5'd0 && m_wstrb == 4'hf) ? stall_x : 0)) m_ready <= 1'b1;
      else wait_q <= wait_q + 1;
    end else begin
      m_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      p_valid <= 1'b0;
      p_done  <= 1'b0;
      vlen    <= 0;
    end else begin
      if (p_valid && !p_done && m_valid &&
          (m_addr != p_addr || m_wdata != p_wdata || m_wstrb != p_wstrb))
        stab_viol <= stab_viol + 1;
      if (p_done && m_valid) gap_viol <= gap_viol + 1;
      if (m_valid && m_ready) begin
        vlen <= 0;
        if (m_addr == 5'd0 && m_wstrb == 4'hf) x_len <= vlen + 1;
      end else if (m_valid) begin
        vlen <= vlen + 1;
      end
      p_valid <= m_valid;
      p_done  <= m_valid && m_ready;
      p_addr  <= m_addr;
      p_wdata <= m_wdata;
      p_wstrb <= m_wstrb;
      if (res_valid && res_ready) begin
        r_data[res_n] <= res_data;
        r_idx[res_n]  <= res_idx;
        r_last[res_n] <= res_last;
        res_n         <= res_n + 1;
      end
      if (res_valid) rv_cnt <= rv_cnt + 1;
      if (done) done_n <= done_n + 1;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] n);
    @(posedge clk);
    #1 start = 1'b1;
    n_points = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] x, input logic [31:0] y);
    bit ok = 1'b0;
    pt_x = x;
    pt_y = y;
    pt_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pt_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1 pt_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL feed: pt_ready seen=%b required=1 for point (%0d,%0d)", ok, x, y);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done seen=%b required=1 within %0d cycles", name, seen, bound);
    end
    idle(2);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({m_valid, pt_ready, res_valid, busy, done, timeout_err, res_last} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000000",
               {m_valid, pt_ready, res_valid, busy, done, timeout_err, res_last});
    end
    #1 rst = 1'b1;
    idle(2);
    checks++;
    if ({m_valid, busy, done, res_data, m_addr, m_wstrb} !== '0) begin
      failures++;
      $display("FAIL reset_release: m_valid=%b busy=%b done=%b res_data=%h required all 0",
               m_valid, busy, done, res_data);
    end
  endtask

  task automatic test_basic;
    int lb, rb, db;
    logic [4:0]  ea [22];
    logic [31:0] ew [22];
    logic        ewr [22];
    logic [31:0] xs [2];
    logic [31:0] ys [2];
    int e;
    xs = '{32'd3, 32'd10};
    ys = '{32'd4, 32'd20};
    e = 0;
    for (int p = 0; p < 2; p++) begin
      ea[e] = 5'd0; ew[e] = xs[p]; ewr[e] = 1'b1; e++;
      ea[e] = 5'd1; ew[e] = ys[p]; ewr[e] = 1'b1; e++;
      ea[e] = 5'd3; ew[e] = '0;    ewr[e] = 1'b0; e++;
      for (int k = 0; k < 4; k++) begin
        ea[e] = 5'd2; ew[e] = k; ewr[e] = 1'b1; e++;
        ea[e] = 5'd4; ew[e] = '0; ewr[e] = 1'b0; e++;
      end
    end
    done_after = 0;
    lb = log_n; rb = res_n; db = done_n;
    start_run(16'd2);
    feed(32'd3, 32'd4);
    feed(32'd10, 32'd20);
    wait_done("basic", 400);
    checks++;
    if (log_n - lb !== 22) begin
      failures++;
      $display("FAIL basic_bus_count: got %0d required 22", log_n - lb);
    end
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (log_addr[lb+i] !== ea[i] || log_wr[lb+i] !== ewr[i] ||
          (ewr[i] && log_wdata[lb+i] !== ew[i])) begin
        failures++;
        $display("FAIL basic_bus[%0d]: addr=%0d wr=%b wdata=%h required addr=%0d wr=%b wdata=%h",
                 i, log_addr[lb+i], log_wr[lb+i], log_wdata[lb+i], ea[i], ewr[i], ew[i]);
      end
    end
    checks++;
    if (res_n - rb !== 8) begin
      failures++;
      $display("FAIL basic_res_count: got %0d required 8", res_n - rb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_data[rb+i] !== 32'h100 + 32'(i % 4) || r_idx[rb+i] !== 2'(i % 4) ||
          r_last[rb+i] !== (i == 7)) begin
        failures++;
        $display("FAIL basic_res[%0d]: data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                 i, r_data[rb+i], r_idx[rb+i], r_last[rb+i], 32'h100 + 32'(i % 4), i % 4, i == 7);
      end
    end
    checks++;
    if (done_n - db !== 1) begin
      failures++;
      $display("FAIL basic_done_pulses: got %0d required 1", done_n - db);
    end
  endtask

  task automatic test_stall;
    int lb, nx;
    stall_x = 5;
    done_after = 0;
    lb = log_n;
    start_run(16'd1);
    feed(32'd5, 32'd6);
    wait_done("stall", 400);
    stall_x = 0;
    nx = 0;
    for (int i = lb; i < log_n; i++) if (log_addr[i] == 5'd0 && log_wr[i]) nx++;
    checks++;
    if (nx !== 1) begin
      failures++;
      $display("FAIL stall_x_writes: got %0d required 1", nx);
    end
    checks++;
    if (x_len !== 7) begin
      failures++;
      $display("FAIL stall_valid_len: got %0d required 7", x_len);
    end
    checks++;
    if (stab_viol !== 0) begin
      failures++;
      $display("FAIL bus_stable: violations=%0d required 0", stab_viol);
    end
    checks++;
    if (gap_viol !== 0) begin
      failures++;
      $display("FAIL bus_gap: violations=%0d required 0", gap_viol);
    end
  endtask

  task automatic test_poll;
    int lb, rb, np;
    done_after = 3;
    lb = log_n; rb = res_n;
    start_run(16'd1);
    feed(32'd7, 32'd9);
    wait_done("poll", 400);
    np = 0;
    for (int i = lb; i < log_n; i++) begin
      if (log_addr[i] == 5'd2 && log_wr[i]) break;
      if (log_addr[i] == 5'd3 && !log_wr[i]) np++;
    end
    checks++;
    if (np !== 4) begin
      failures++;
      $display("FAIL poll_reads: got %0d required 4", np);
    end
    checks++;
    if (timeout_err !== 1'b0 || res_n - rb !== 4) begin
      failures++;
      $display("FAIL poll_outcome: timeout_err=%b results=%0d required 0 and 4",
               timeout_err, res_n - rb);
    end
  endtask

  task automatic test_timeout;
    int lb, vb, db, np;
    done_after = -1;
    lb = log_n; vb = rv_cnt; db = done_n;
    start_run(16'd1);
    feed(32'd1, 32'd2);
    wait_done("timeout", 400);
    np = 0;
    for (int i = lb; i < log_n; i++) if (log_addr[i] == 5'd3 && !log_wr[i]) np++;
    checks++;
    if (np !== 8) begin
      failures++;
      $display("FAIL timeout_polls: got %0d required 8", np);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag: got %b required 1", timeout_err);
    end
    checks++;
    if (rv_cnt - vb !== 0 || done_n - db !== 1) begin
      failures++;
      $display("FAIL timeout_outputs: res_valid cycles=%0d done pulses=%0d required 0 and 1",
               rv_cnt - vb, done_n - db);
    end
    done_after = 0;
    start_run(16'd0);
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got %b required 0", timeout_err);
    end
    wait_done("timeout_clear", 20);
  endtask

  task automatic test_back_to_back_hold;
    int lb, rb, db;
    bit seen = 1'b0;
    logic [31:0] d0;
    done_after = 0;
    res_ready = 1'b0;
    rb = res_n; db = done_n;
    start_run(16'd1);
    feed(32'd7, 32'd8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL hold_res_valid: seen=%b required 1", seen);
    end
    d0 = res_data;
    lb = log_n;
    start_run(16'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'h100 || m_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle[%0d]: res_valid=%b res_data=%h m_valid=%b required 1 100 0",
                 i, res_valid, res_data, m_valid);
      end
    end
    checks++;
    if (log_n !== lb || d0 !== 32'h100) begin
      failures++;
      $display("FAIL hold_bus: transfers=%0d first data=%h required 0 and 100", log_n - lb, d0);
    end
    #1 res_ready = 1'b1;
    wait_done("hold", 200);
    checks++;
    if (res_n - rb !== 4 || done_n - db !== 1) begin
      failures++;
      $display("FAIL hold_totals: results=%0d done pulses=%0d required 4 and 1",
               res_n - rb, done_n - db);
    end
  endtask

  task automatic test_reset_mid;
    int rb, lb;
    bit seen = 1'b0;
    done_after = 0;
    rb = res_n;
    start_run(16'd1);
    feed(32'd11, 32'd12);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_valid && m_addr == 5'd4) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_reach: RD_OUT seen=%b required 1", seen);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({m_valid, busy, res_valid, pt_ready, done, res_data, m_addr, m_wdata, m_wstrb} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: m_valid=%b busy=%b res_valid=%b res_data=%h m_addr=%0d required all 0",
               m_valid, busy, res_valid, res_data, m_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    checks++;
    if (res_n - rb !== 0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: results=%0d busy=%b m_valid=%b required 0 0 0",
               res_n - rb, busy, m_valid);
    end
    lb = log_n;
    @(posedge clk);
    #1 start = 1'b1;
    n_points = 16'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_early: done=%b required 0 one cycle after start", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: done=%b required 1 two cycles after start", done);
    end
    idle(2);
    checks++;
    if (log_n !== lb || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_traffic: transfers=%0d done=%b required 0 0", log_n - lb, done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_poll();
    test_timeout();
    test_back_to_back_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
